// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int PC_W_DEF    = 13;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [PC_W_DEF-1:0]    pc_plus4;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode valid/ready handshake bundle.
interface fetch_queue_if #(
    parameter int PC_W    = 13,
    parameter int INSTR_W = 32
);

    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic [INSTR_W-1:0] instr;

    modport master (
        output valid,
        output pc,
        output pc_plus4,
        output instr,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  pc_plus4,
        input  instr,
        output ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetch entries with push/pop/clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC-enable credit logic, imem response capture, decode queue.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [PC_W-1:0]        pc_plus4_i,
    input  logic                   flush_i,
    output logic                   pc_en_o,
    input  logic [INSTR_W-1:0]     imem_rdata_i,
    fetch_queue_if.master          id_if,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PC_W-1:0]   inflight_pc4_q, inflight_pc4_d;

    logic              deq;
    logic              push;
    logic              head_valid;
    logic [CW-1:0]     count;
    logic [CW:0]       credit;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign head_valid = (count != '0);
    assign deq        = head_valid & id_if.ready & ~flush_i;
    assign push       = inflight_q & ~flush_i;

    // Issued fetches reserve a slot before their data arrives.
    assign credit  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign pc_en_o = rst_ni & (flush_i | deq | (credit < DEPTH_C));

    always_comb begin
        inflight_d     = pc_en_o & ~flush_i;
        inflight_pc_d  = inflight_pc_q;
        inflight_pc4_d = inflight_pc4_q;
        if (pc_en_o) begin
            inflight_pc_d  = pc_i;
            inflight_pc4_d = pc_plus4_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            inflight_pc4_q <= '0;
        end else begin
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
            inflight_pc4_q <= inflight_pc4_d;
        end
    end

    always_comb begin
        push_entry          = '0;
        push_entry.pc       = inflight_pc_q;
        push_entry.pc_plus4 = inflight_pc4_q;
        push_entry.instr    = imem_rdata_i;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (deq),
        .head_o      (head),
        .count_o     (count)
    );

    assign id_if.valid    = head_valid;
    assign id_if.pc       = head.pc;
    assign id_if.pc_plus4 = head.pc_plus4;
    assign id_if.instr    = head_valid ? head.instr : NOP_INSTR;
    assign occupancy_o    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a PC-block and sync-imem model.
module tb_fetch_queue;

    import fetch_pkg::*;

    localparam int PC_W    = 13;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc4;
    logic [PC_W-1:0]    target = '0;
    logic [INSTR_W-1:0] rdata;
    logic               pc_en;
    logic [2:0]         occ;

    int total = 0;
    int bad   = 0;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) id_if ();

    fetch_queue #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_i         (pc),
        .pc_plus4_i   (pc4),
        .flush_i      (flush),
        .pc_en_o      (pc_en),
        .imem_rdata_i (rdata),
        .id_if        (id_if),
        .occupancy_o  (occ)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [PC_W-1:0] a);
        return {16'hC0DE, 3'b000, a};
    endfunction

    assign pc4 = pc + 13'd4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (pc_en)
            pc <= flush ? target : pc4;
    end

    always @(posedge clk) rdata <= instr_of(pc);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic reset_seq;
        rst_n       = 1'b0;
        flush       = 1'b0;
        id_if.ready = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (!id_if.valid && n < budget) begin
            tick();
            n++;
        end
        if (!id_if.valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic chk_head(input string tag, input logic [PC_W-1:0] epc);
        chk({tag, "_valid"}, id_if.valid, 1);
        chk({tag, "_pc"}, id_if.pc, epc);
        chk({tag, "_pc4"}, id_if.pc_plus4, epc + 13'd4);
        chk({tag, "_instr"}, id_if.instr, instr_of(epc));
    endtask

    initial begin
        int n;
        int got;
        id_if.ready = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_valid", id_if.valid, 0);
        chk("rst_instr", id_if.instr, NOP_INSTR);
        chk("rst_pc", id_if.pc, 0);
        chk("rst_occ", occ, 0);
        chk("rst_pc_en", pc_en, 0);

        // streaming with ready held high
        rst_n = 1'b1;
        id_if.ready = 1'b1;
        settle();
        chk("s_first_en", pc_en, 1);
        chk("s_c0_valid", id_if.valid, 0);
        tick();
        chk("s_c1_valid", id_if.valid, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_head($sformatf("s%0d", k), 13'(4 * k));
            chk($sformatf("s%0d_en", k), pc_en, 1);
            tick();
        end

        // fill to DEPTH with ready low, then drain
        reset_seq();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (pc_en) n++;
            tick();
        end
        chk("fill_issues", n, 4);
        chk("fill_occ", occ, 4);
        chk("fill_en", pc_en, 0);
        chk("fill_pc_held", pc, 16);
        id_if.ready = 1'b1;
        settle();
        chk("drain_en_reassert", pc_en, 1);
        for (int k = 0; k < 6; k++) begin
            chk_head($sformatf("d%0d", k), 13'(4 * k));
            tick();
        end

        // flush a full queue
        reset_seq();
        for (int i = 0; i < 6; i++) tick();
        chk("ff_occ", occ, 4);
        chk("ff_pc", pc, 13'h010);
        flush  = 1'b1;
        target = 13'h100;
        settle();
        chk("ff_en", pc_en, 1);
        tick();
        flush = 1'b0;
        chk("ff_occ0", occ, 0);
        chk("ff_valid0", id_if.valid, 0);
        chk("ff_nop", id_if.instr, NOP_INSTR);
        id_if.ready = 1'b1;
        wait_valid(4, "ff");
        chk_head("ff_first", 13'h100);
        tick();
        chk_head("ff_second", 13'h104);

        // flush with valid head, ready and inflight; back-to-back
        tick();
        chk("fi_head_valid", id_if.valid, 1);
        flush  = 1'b1;
        target = 13'h200;
        settle();
        chk("fi_en", pc_en, 1);
        tick();
        target = 13'h300;
        tick();
        flush = 1'b0;
        chk("fi_occ0", occ, 0);
        chk("fi_valid0", id_if.valid, 0);
        wait_valid(4, "fi");
        chk_head("fi_first", 13'h300);
        tick();
        chk_head("fi_second", 13'h304);
        tick();
        chk_head("fi_third", 13'h308);

        // wrap-around with random ready
        reset_seq();
        got = 0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            id_if.ready = 1'($urandom_range(0, 1));
            settle();
            if (id_if.valid && id_if.ready) begin
                chk($sformatf("w%0d_pc", got), id_if.pc, 13'(4 * got));
                chk($sformatf("w%0d_instr", got), id_if.instr,
                    instr_of(13'(4 * got)));
                got++;
            end
            tick();
        end
        chk("wrap_count", got, 10);

        // asynchronous reset mid-operation
        reset_seq();
        for (int i = 0; i < 4; i++) tick();
        chk("mr_occ", occ, 3);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", id_if.valid, 0);
        chk("mr_occ0", occ, 0);
        chk("mr_instr", id_if.instr, NOP_INSTR);
        chk("mr_pc", id_if.pc, 0);
        chk("mr_en", pc_en, 0);
        tick();
        rst_n = 1'b1;
        id_if.ready = 1'b1;
        settle();
        chk("mr_restart_en", pc_en, 1);
        wait_valid(4, "mr");
        chk_head("mr_first", 13'h000);
        tick();
        chk_head("mr_second", 13'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
